// File: rtl/multiword_add_sequencer_if.sv
// Bundles the operand, adder and result channels of the multi-word add sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface multiword_add_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_cout;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Feeds an external slice adder one WIDTH-bit slice per beat (LSB first) and
// registers its result, carrying the slice carry between beats.
module multiword_add_sequencer #(
  parameter int WIDTH = 3,
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multiword_add_sequencer_if.slave bus
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             carry_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_last_q;
  logic             out_cout_q;

  logic accept;
  logic last_beat;

  // Output register is 1-deep; it may refill in the cycle it drains.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));

  assign bus.add_a   = bus.in_a;
  assign bus.add_b   = bus.in_b;
  assign bus.add_cin = (state == IDLE) ? bus.in_cin : carry_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;

  // Flush outranks accept, so a slice offered alongside flush is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= bus.add_sum;
      out_last_q  <= last_beat;
      if (last_beat) begin
        out_cout_q <= bus.add_cout;
        carry_q    <= 1'b0;
        beat_cnt   <= '0;
        state      <= IDLE;
      end else begin
        out_cout_q <= 1'b0;
        carry_q    <= bus.add_cout;
        beat_cnt   <= beat_cnt + 1'b1;
        state      <= BUSY;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed plus randomized checks of the multi-word add sequencer against a
// whole-operand arithmetic reference, with a slice adder model on add_*.
module tb_multiword_add_sequencer;
  localparam int WIDTH = 3;
  localparam int BEATS = 4;
  localparam int TOTAL = WIDTH * BEATS;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multiword_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  multiword_add_sequencer #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Slice adder standing in for ripple_carry
  assign {bus.add_cout, bus.add_sum} =
    (WIDTH+1)'(bus.add_a) + (WIDTH+1)'(bus.add_b) + (WIDTH+1)'(bus.add_cin);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOTAL:0] ref_sum(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                                             input logic cin);
    return (TOTAL+1)'(a) + (TOTAL+1)'(b) + (TOTAL+1)'(cin);
  endfunction

  // Offers beats [first, stop) of a + b + cin with out_ready high, one per cycle.
  task automatic run_op(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b, input logic cin,
                        input int first, input int stop);
    logic [TOTAL:0] total;
    total = ref_sum(a, b, cin);
    for (int i = first; i < stop; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_a      = a[WIDTH*i +: WIDTH];
      bus.in_b      = b[WIDTH*i +: WIDTH];
      bus.in_cin    = (i == 0) ? cin : 1'($urandom);
      bus.out_ready = 1'b1;
      #1;
      check("in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check($sformatf("out_sum[%0d]", i), 32'(bus.out_sum), 32'(total[WIDTH*i +: WIDTH]));
      check("out_last", 32'(bus.out_last), (i == BEATS-1) ? 32'd1 : 32'd0);
      check("out_cout", 32'(bus.out_cout), (i == BEATS-1) ? 32'(total[TOTAL]) : 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_a     = 3'($urandom);
    bus.in_b     = 3'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  task automatic idle_drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_sum"},   32'(bus.out_sum),   32'd0);
    check({tag, "_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_cout"},  32'(bus.out_cout),  32'd0);
  endtask

  initial begin
    logic [TOTAL-1:0] ra, rb;
    logic             rc;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Test 1 and 2: carry propagation and final carry-out
    run_op(12'h123, 12'h456, 1'b0, 0, BEATS);
    run_op(12'hFFF, 12'h001, 1'b0, 0, BEATS);
    idle_drain();

    // Test 3: operation carry-in, then no leakage into the next op
    run_op(12'h000, 12'h000, 1'b1, 0, BEATS);
    run_op(12'h000, 12'h000, 1'b0, 0, BEATS);
    idle_drain();

    // Test 4: backpressure after beat index 1 of test 1
    run_op(12'h123, 12'h456, 1'b0, 0, 2);
    bus.in_valid  = 1'b1;
    bus.in_a      = 3'd4;
    bus.in_b      = 3'd1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum", 32'(bus.out_sum), 32'd7);
    end
    run_op(12'h123, 12'h456, 1'b0, 2, BEATS);
    idle_drain();

    // Test 5: flush after two beats of test 2 drops the offered slice
    run_op(12'hFFF, 12'h001, 1'b0, 0, 2);
    bus.in_valid  = 1'b1;
    bus.in_a      = 3'd7;
    bus.in_b      = 3'd0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.in_cin = 1'b0;
    #1;
    check("flush_add_cin0", 32'(bus.add_cin), 32'd0);
    bus.in_cin = 1'b1;
    #1;
    check("flush_add_cin1", 32'(bus.add_cin), 32'd1);
    run_op(12'h123, 12'h456, 1'b0, 0, BEATS);

    // Test 6: reset mid-op, then full ops back to back
    run_op(12'h123, 12'h456, 1'b0, 0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cleared("midreset");
    rst_n = 1'b1;
    run_op(12'hFFF, 12'h001, 1'b0, 0, BEATS);

    // Randomized back-to-back operations
    for (int n = 0; n < 20; n++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 0, BEATS);
    end
    idle_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
